mem_bank: RTL and testbench

//  Parametrised single-port on-chip memory bank; successor to the fixed 32-bit instruction/data store.

---
 rtl/mem_bank_pkg.sv | 19 +
 rtl/mem_bank_if.sv | 31 +++
 rtl/mem_bank_array.sv | 70 +++++++
 rtl/mem_bank.sv | 110 +++++++++++
 tb/tb_mem_bank.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_bank_pkg.sv
// Shared definitions for the mem_bank slice: default sizes, clear FSM states
// and the parity-width helper used by the array and the top.
package mem_bank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4096;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // One parity bit per byte lane
    function automatic int par_w(int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_bank_if.sv
// Request/response bus of the memory bank; master drives requests,
// slave (the bank) drives ready, read data and status.
interface mem_bank_if
    import mem_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic                  req_i;
    logic                  we_i;
    logic [DATA_W/8-1:0]   be_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     data_i;
    logic                  ready_o;
    logic                  rvalid_o;
    logic [DATA_W-1:0]     data_o;
    logic                  busy_o;
    logic                  perr_o;

    modport master (
        output req_i, we_i, be_i, addr_i, data_i,
        input  ready_o, rvalid_o, data_o, busy_o, perr_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, data_i,
        output ready_o, rvalid_o, data_o, busy_o, perr_o
    );

endinterface

// File: rtl/mem_bank_array.sv
// Word storage with per-byte write enables and registered read port.
// Per-byte even parity is stored and checked when MEM_BANK_PARITY_EN is defined.
module mem_bank_array
    import mem_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int NB    = par_w(DATA_W),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) mem[idx][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
    end

    // Read data survives writes; only a read or reset changes it
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end
    end

`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0] par [DEPTH];

    function automatic logic [NB-1:0] byte_par(logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int k = 0; k < NB; k++) p[k] = ^d[k*8 +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) par[idx][k] <= ^wdata[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rerr <= 1'b0;
        end else if (en && !we) begin
            rerr <= |(byte_par(mem[idx]) ^ par[idx]);
        end
    end
`else
    assign rerr = 1'b0;
`endif

endmodule

// File: rtl/mem_bank.sv
// Single-port memory bank: post-reset clear FSM, req/ready handshake, 1-cycle reads.
// Optional per-byte parity checking is enabled with MEM_BANK_PARITY_EN.
module mem_bank
    import mem_bank_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    mem_bank_if.slave bus
);

    localparam int NB    = par_w(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam state_e RST_ST = CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;

    state_e            state, state_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic              accept;
    logic              rd_acc;
    logic              rvalid_q;
    logic              rerr;
    logic              arr_en;
    logic              arr_we;
    logic [NB-1:0]     arr_be;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_wdata;
    logic [IDX_W-1:0]  addr_idx;
    logic              unused_addr;

    assign addr_idx    = bus.addr_i[IDX_W+1:2];
    assign unused_addr = ^{bus.addr_i[ADDR_W-1:IDX_W+2], bus.addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_ST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            ST_CLEAR: begin
                cnt_nxt = cnt + IDX_W'(1);
                if (cnt == IDX_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = RST_ST;
        endcase
    end

    // Status is gated by rst so the reset cycle itself shows idle outputs
    assign bus.ready_o = (state == ST_IDLE) && !rst;
    assign bus.busy_o  = (state == ST_CLEAR) && !rst;

    assign accept = bus.req_i && bus.ready_o;
    assign rd_acc = accept && !bus.we_i;

    always_comb begin
        arr_en    = accept;
        arr_we    = bus.we_i;
        arr_be    = bus.be_i;
        arr_idx   = addr_idx;
        arr_wdata = bus.data_i;
        if (bus.busy_o) begin
            arr_en    = 1'b1;
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_idx   = cnt;
            arr_wdata = '0;
        end
    end

    mem_bank_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (arr_en),
        .we    (arr_we),
        .be    (arr_be),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (bus.data_o),
        .rerr  (rerr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.perr_o   = rvalid_q && rerr;

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank (DEPTH=16): clear timing, byte enables,
// aliasing, back-to-back reads, reset behaviour and optional parity.
module tb_mem_bank;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;
    int   n;
    logic saw_rvalid;

    mem_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_bank #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .CLEAR_ON_RST (1'b1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b1;
        bus.addr_i = a;
        bus.data_i = d;
        bus.be_i   = be;
        tick();
        bus.req_i  = 1'b0;
        bus.we_i   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = a;
        bus.be_i   = 4'h0;
        tick();
        bus.req_i  = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst        = 1'b1;
        bus.req_i  = 1'b0;
        bus.we_i   = 1'b0;
        bus.be_i   = 4'h0;
        bus.addr_i = '0;
        bus.data_i = '0;
        tick();
        tick();
        chk("rst_ready",  {31'd0, bus.ready_o},  32'd0);
        chk("rst_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        chk("rst_data",   bus.data_o,            32'd0);
        chk("rst_busy",   {31'd0, bus.busy_o},   32'd0);
        chk("rst_perr",   {31'd0, bus.perr_o},   32'd0);

        // Clear: busy for exactly DEPTH cycles after release
        rst = 1'b0;
        #1;
        n = 0;
        while (bus.busy_o && n < 100) begin
            n++;
            tick();
        end
        chk("clr_cycles", n, 32'd16);
        chk("clr_ready", {31'd0, bus.ready_o}, 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            rd(32'(i * 4));
            chk("clr_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
            chk("clr_zero", bus.data_o, 32'd0);
        end

        // Byte-enable merge; writes do not disturb data_o or rvalid_o
        wr(32'h40, 32'hDEADBEEF, 4'hF);
        chk("wr_no_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        wr(32'h40, 32'h00005500, 4'b0010);
        chk("wr_hold_data", bus.data_o, 32'd0);
        rd(32'h40);
        chk("be_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("be_merge", bus.data_o, 32'hDEAD55EF);

        // Aliasing: 0x44 maps to the same word as 0x04
        wr(32'h04, 32'h12345678, 4'hF);
        rd(32'h44);
        chk("alias_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("alias_data", bus.data_o, 32'h12345678);
        tick();
        chk("alias_pulse", {31'd0, bus.rvalid_o}, 32'd0);
        chk("alias_hold", bus.data_o, 32'h12345678);

        wr(32'h04, 32'hFFFFFFFF, 4'h0);
        rd(32'h04);
        chk("be0_noop", bus.data_o, 32'h12345678);

        // Back-to-back reads
        wr(32'h08, 32'hA5A5A5A5, 4'hF);
        rd(32'h00);
        chk("b2b0_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("b2b0_data", bus.data_o, 32'hDEAD55EF);
        rd(32'h04);
        chk("b2b1_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("b2b1_data", bus.data_o, 32'h12345678);
        rd(32'h08);
        chk("b2b2_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("b2b2_data", bus.data_o, 32'hA5A5A5A5);
        chk("b2b_perr", {31'd0, bus.perr_o}, 32'd0);
        tick();
        chk("b2b_end_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        chk("b2b_end_hold", bus.data_o, 32'hA5A5A5A5);

        // Reset in the cycle after a read wins
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = 32'h40;
        tick();
        chk("pre_rst_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        bus.req_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_rd_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        chk("rst_rd_data", bus.data_o, 32'd0);

        // Reset mid-clear at counter 7 restarts the full sequence
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = 32'h40;
        #1;
        n = 0;
        saw_rvalid = 1'b0;
        while (bus.busy_o && n < 100) begin
            if (bus.rvalid_o) saw_rvalid = 1'b1;
            n++;
            tick();
        end
        bus.req_i = 1'b0;
        chk("reclr_cycles", n, 32'd16);
        chk("reclr_drop", {31'd0, saw_rvalid}, 32'd0);
        chk("reclr_ready", {31'd0, bus.ready_o}, 32'd1);
        tick();
        chk("reclr_no_late", {31'd0, bus.rvalid_o}, 32'd0);
        rd(32'h40);
        chk("reclr_zero", bus.data_o, 32'd0);

`ifdef MEM_BANK_PARITY_EN
        wr(32'h0C, 32'h0F0F0F0F, 4'hF);
        rd(32'h0C);
        chk("par_clean", {31'd0, bus.perr_o}, 32'd0);
        u_dut.u_array.mem[3] = u_dut.u_array.mem[3] ^ 32'h1;
        rd(32'h0C);
        chk("par_data", bus.data_o, 32'h0F0F0F0E);
        chk("par_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("par_err", {31'd0, bus.perr_o}, 32'd1);
        rd(32'h08);
        chk("par_clean2", {31'd0, bus.perr_o}, 32'd0);
`else
        wr(32'h0C, 32'h0F0F0F0F, 4'hF);
        rd(32'h0C);
        chk("nopar_data", bus.data_o, 32'h0F0F0F0F);
        chk("nopar_perr", {31'd0, bus.perr_o}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
